// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RISC core: sequences fetch, decode,
// execute, memory access and write-back, stalling on mem_ready for every memory access.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // The branch condition is applied in the datapath, so zero is not needed here.
  logic unused_zero_s;
  assign unused_zero_s = zero;

  assign state = state_r;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore output decode; memory handshakes qualify a few outputs.
  always_comb begin
    next_state_s  = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
          OP_RTYPE:     next_state_s = S_R_EXEC;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_J:         next_state_s = S_JUMP;
          OP_ADDI:      next_state_s = S_ADDI_EXEC;
          default: begin
            next_state_s = S_FETCH;
            illegal_op   = 1'b1;
            instr_done   = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          next_state_s = S_MEM_RD;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_R_EXEC: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b10;
        next_state_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        next_state_s = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle trace (state, outputs, stimulus) and replayed against the DUT.
module tb_multicycle_ctrl;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] JMP   = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
    outs_t      o;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  cyc_t  exp_q[$];
  cyc_t  cur;
  bit    chk_en = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  outs_t act_o;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  assign act_o = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] jop();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op, input outs_t o);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.op = op; c.o = o;
    exp_q.push_back(c);
  endtask

  // Expected trace of one instruction: fw fetch waits, mw data-memory waits.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    outs_t o;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
      push(4'd0, 1'b0, jop(), o);
    end
    o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(4'd0, 1'b1, jop(), o);
    o = '0; o.alu_src_b = 2'b11;
    case (op)
      LW, SW: begin
        push(4'd1, rb(), op, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        push(4'd2, rb(), op, o);
        if (op == LW) begin
          o = '0; o.mem_read = 1'b1; o.iord = 1'b1;
          for (int i = 0; i < mw; i++) push(4'd3, 1'b0, jop(), o);
          push(4'd3, 1'b1, jop(), o);
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
          push(4'd4, rb(), jop(), o);
        end else begin
          o = '0; o.mem_write = 1'b1; o.iord = 1'b1;
          for (int i = 0; i < mw; i++) push(4'd5, 1'b0, jop(), o);
          o.instr_done = 1'b1;
          push(4'd5, 1'b1, jop(), o);
        end
      end
      RTYPE: begin
        push(4'd1, rb(), op, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b10;
        push(4'd6, rb(), jop(), o);
        o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
        push(4'd7, rb(), jop(), o);
      end
      BEQ: begin
        push(4'd1, rb(), op, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
        o.pc_source = 2'b01; o.instr_done = 1'b1;
        push(4'd8, rb(), jop(), o);
      end
      JMP: begin
        push(4'd1, rb(), op, o);
        o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1;
        push(4'd9, rb(), jop(), o);
      end
      ADDI: begin
        push(4'd1, rb(), op, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        push(4'd10, rb(), jop(), o);
        o = '0; o.reg_write = 1'b1; o.instr_done = 1'b1;
        push(4'd11, rb(), jop(), o);
      end
      default: begin
        o.illegal_op = 1'b1; o.instr_done = 1'b1;
        push(4'd1, rb(), op, o);
      end
    endcase
  endtask

  task automatic step();
    cyc_t c;
    c = exp_q.pop_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    opcode = c.op;
    mem_ready = c.rdy;
    zero = rb();
    cur = c;
    chk_en = 1'b1;
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) step();
  endtask

  // Two reset edges, then FETCH decode with mem_ready low must be visible.
  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    chk_en = 1'b0; rst_n = 1'b0; mem_ready = 1'b0; opcode = jop();
    @(posedge clk);
    #1;
    opcode = jop();
    @(negedge clk);
    chk({name, "_state"}, 32'(state), 32'd0);
    chk({name, "_outs"}, 32'(act_o), 32'(18'b0001000000_01_00_00_0_0));
  endtask

  // Single compare process: DUT against the expected trace on every active cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(cur.st));
      chk("outs", 32'(act_o), 32'(cur.o));
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int k;
    ops[0] = RTYPE; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI;
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b000000; zero = 1'b0;
    do_reset("rst_init");

    add_instr(RTYPE, 0, 0);
    chk("len_rtype", 32'(exp_q.size()), 32'd4);
    chk("model_rtype_aluop", 32'(exp_q[2].o.alu_op), 32'd2);
    run_all();
    add_instr(LW, 0, 3);
    chk("len_lw_3wait", 32'(exp_q.size()), 32'd8);
    run_all();
    add_instr(SW, 0, 0);
    chk("len_sw", 32'(exp_q.size()), 32'd4);
    add_instr(BEQ, 0, 0);
    chk("len_sw_beq", 32'(exp_q.size()), 32'd7);
    run_all();
    add_instr(JMP, 0, 0);
    chk("len_j", 32'(exp_q.size()), 32'd3);
    chk("model_j_pcsrc", 32'(exp_q[2].o.pc_source), 32'd2);
    run_all();
    add_instr(ADDI, 0, 0);
    chk("len_addi", 32'(exp_q.size()), 32'd4);
    run_all();
    add_instr(6'b111111, 0, 0);
    chk("len_illegal", 32'(exp_q.size()), 32'd2);
    chk("model_illegal_flag", 32'(exp_q[1].o.illegal_op), 32'd1);
    run_all();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) < 6) op = ops[$urandom_range(0, 5)];
      else op = jop();
      add_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      run_all();
    end

    // Reset from an arbitrary point inside an instruction.
    add_instr(ops[$urandom_range(0, 5)], 1, 4);
    k = int'($urandom_range(1, exp_q.size() - 1));
    for (int i = 0; i < k; i++) step();
    exp_q.delete();
    do_reset("rst_rand");

    // Reset while a load is waiting on memory.
    add_instr(LW, 0, 5);
    do step(); while (cur.st != 4'd3 && exp_q.size() > 0);
    exp_q.delete();
    do_reset("rst_memrd");

    add_instr(ADDI, 1, 0);
    run_all();
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RISC core.
- Sequences instruction fetch, decode, execute, memory access and write-back over several cycles.
- Drives the datapath muxes, register-file and memory enables, and the 2-bit alu_op consumed by the ALU control decoder.
- Waits on a single-bit memory ready handshake for every memory access.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero (branch)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct
- pc_source  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current state encoding (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Encodings 12-15 are unreachable and go to FETCH.
- Reset: on a rising clk edge with rst_n=0, state becomes FETCH. Reset overrides any in-flight memory wait.
- Output defaults: every output not listed for a state is 0. Outputs are Moore-decoded from state, except where qualified by mem_ready.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=mem_ready and pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (computes the branch target). Next state by opcode:
  - LW or SW -> MEM_ADDR
  - RTYPE -> R_EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDI_EXEC
  - any other opcode -> FETCH, with illegal_op=1 and instr_done=1 in this cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD if opcode=LW, otherwise MEM_WR.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready; when mem_ready=1, instr_done=1 and goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH. The PC update itself is gated by zero in the datapath.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- Wait states: a wait is unbounded. mem_read/mem_write stay high and iord stays stable throughout.
- Cycle counts (mem_ready held high):
  - LW 5 cycles; SW 4; R-type 4; ADDI 4
  - BEQ 3; J 3; illegal opcode 2
- Opcode sampling: opcode is sampled only in DECODE and MEM_ADDR; it may change in all other states.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles from a random state -> state=0, all outputs 0 except the FETCH decode (mem_read=1, alu_src_b=01). Releasing reset with mem_ready=1 -> ir_write=1 and pc_write=1 in the first cycle.
- R-type with mem_ready=1: opcode=000000 -> states 0,1,6,7,0. alu_op=10 in state 6. reg_write=1 and reg_dst=1 in state 7. instr_done pulses once in state 7.
- LW with 3 wait cycles in MEM_RD: opcode=100011, mem_ready low for 3 cycles -> state 3 held for 4 cycles with mem_read=1 and iord=1; then state 4 with mem_to_reg=1 and reg_write=1. Total 8 cycles.
- SW then BEQ back-to-back: opcode=101011 then 000100 -> SW path 0,1,2,5 with mem_write=1 for 1 cycle; then BEQ path 0,1,8 with pc_write_cond=1, alu_op=01, pc_source=01.
- J and ADDI: opcode=000010 -> pc_write=1, pc_source=10 in state 9. opcode=001000 -> states 10,11 with alu_src_b=10 and reg_write=1, reg_dst=0.
- Illegal opcode and reset mid-wait: opcode=111111 -> illegal_op=1 and instr_done=1 in DECODE, next state 0. rst_n=0 during MEM_RD with mem_ready=0 -> state=0 next cycle and mem_read re-asserted with iord=0.
